// File: rtl/word_uart_tx.sv
// word_uart_tx: drains 32-bit words from an upstream FIFO and sends each one
// as four 8N1 UART bytes, least significant byte first.
module word_uart_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int BAUD_W = $clog2(CPB);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         word_q, word_d;
    logic [15:0]         words_sent_q, words_sent_d;
    logic                tx_q, tx_d;
    logic                rd_q, rd_d;
    logic                busy_q, busy_d;
    // Goes high one edge after reset release so the first fetch lands no
    // earlier than the second edge.
    logic                arm_q;

    logic                bit_end;

    assign bit_end    = (baud_q == BAUD_W'(CPB - 1));
    assign fifo_rd_en = rd_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

    // Next-state logic; registered outputs are derived from the next state so
    // they line up exactly with the state they belong to.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        idx_d        = idx_q;
        word_d       = word_q;
        words_sent_d = words_sent_q;

        case (state_q)
            S_IDLE: begin
                if (arm_q && en && !fifo_empty) state_d = S_REQ;
            end
            S_REQ: state_d = S_LOAD;
            S_LOAD: begin
                word_d  = fifo_dout;
                idx_d   = 2'd0;
                bit_d   = 3'd0;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == 2'd3) begin
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = word_d[{idx_d, bit_d}];
            default: tx_d = 1'b1;
        endcase
        rd_d   = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            idx_q        <= 2'd0;
            word_q       <= 32'd0;
            words_sent_q <= 16'd0;
            tx_q         <= 1'b1;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            arm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            words_sent_q <= words_sent_d;
            tx_q         <= tx_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            arm_q        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: FIFO model + UART line decoder scoreboard for word_uart_tx.
`timescale 1ns/1ps
module tb_word_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = 32'd0;
    logic        fifo_rd_en, tx, busy;
    logic [15:0] words_sent;

    int vectors = 0;
    int errors  = 0;
    int cyc = 0, rd_cnt = 0, busy_cnt = 0;
    logic [31:0] fq[$];
    logic [7:0]  exp_q[$];
    int          starts[$];

    word_uart_tx #(.CLK_FREQ(16), .BAUD(4)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // FIFO model and activity counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
        end
    end
    always @(negedge clk) fifo_empty <= (fq.size() == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int nbytes);
        fq.push_back(w);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_done();
        int idle = 0;
        int t = 0;
        while (idle < 5 && t < 3000) begin
            @(negedge clk);
            t++;
            idle = busy ? 0 : idle + 1;
        end
        if (t >= 3000) begin
            vectors++;
            errors++;
            $display("FAIL wait_done: timeout after %0d cycles", t);
        end
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (starts.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            vectors++;
            errors++;
            $display("FAIL wait_frames: saw %0d frames, wanted %0d", starts.size(), n);
        end
    endtask

    // Monitor: decodes each UART frame, checks framing and bit widths, and
    // compares the byte against the scoreboard. Frames cut by reset are dropped.
    logic [39:0] s;
    logic [7:0]  got, want;
    bit          ab, ok;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                s = '0;
                ab = 1'b0;
                for (int c = 1; c < 40; c++) begin
                    @(negedge clk);
                    if (rst) begin ab = 1'b1; break; end
                    s[c] = tx;
                end
                if (!ab) begin
                    ok = (s[0] == 1'b0) && (s[36] == 1'b1);
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < 4; j++)
                            if (s[4*k+j] !== s[4*k]) ok = 1'b0;
                    for (int i = 0; i < 8; i++) got[i] = s[4*(i+1)];
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: unexpected byte %0h", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (!ok || got !== want) begin
                            errors++;
                            $display("FAIL frame: got %0h framing_ok=%0d expected %0h", got, ok, want);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rd0, bz0, b0, bad;
    initial begin
        // Reset held with a word waiting in the FIFO
        push_word(32'h44332211, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_rd", {31'd0, fifo_rd_en}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ws", {16'd0, words_sent}, 32'd0);
        end
        rd0 = rd_cnt; bz0 = busy_cnt;
        rst = 1'b0;
        @(negedge clk);
        chk("rd_after_1st_edge", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        chk("rd_after_2nd_edge", {31'd0, fifo_rd_en}, 32'd1);
        wait_done();
        chk("w1_rd_pulses", rd_cnt - rd0, 32'd1);
        chk("w1_busy_cycles", busy_cnt - bz0, 32'd162);
        chk("w1_words_sent", {16'd0, words_sent}, 32'd1);

        // Two words back to back
        rd0 = rd_cnt; bz0 = busy_cnt; b0 = starts.size();
        push_word(32'hA5C30F81, 4);
        push_word(32'h00FF7E01, 4);
        wait_done();
        chk("w2_rd_pulses", rd_cnt - rd0, 32'd2);
        chk("w2_busy_cycles", busy_cnt - bz0, 32'd324);
        chk("w2_words_sent", {16'd0, words_sent}, 32'd3);
        chk("w2_frames", starts.size() - b0, 32'd8);
        if (starts.size() >= b0 + 5) begin
            chk("byte_spacing", starts[b0+1] - starts[b0], 32'd40);
            chk("word_gap", starts[b0+4] - starts[b0+3], 32'd43);
        end

        // en dropped during byte 1 with another word queued
        rd0 = rd_cnt; bz0 = busy_cnt; b0 = starts.size();
        push_word(32'hDEADBEEF, 4);
        fq.push_back(32'h0BADF00D);
        wait_frames(b0 + 2);
        en = 1'b0;
        wait_done();
        chk("en_rd_pulses", rd_cnt - rd0, 32'd1);
        chk("en_busy_cycles", busy_cnt - bz0, 32'd162);
        chk("en_words_sent", {16'd0, words_sent}, 32'd4);
        chk("en_fifo_left", fq.size(), 32'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(32'h0BADF00D >> (8*i)));
        en = 1'b1;
        wait_done();
        chk("en_resume_ws", {16'd0, words_sent}, 32'd5);

        // Reset during a data bit of byte 2 (byte 2 is all zeros)
        b0 = starts.size();
        push_word(32'h12005A3C, 2);
        push_word(32'h9E8D7C6B, 4);
        wait_frames(b0 + 3);
        repeat (10) @(negedge clk);
        chk("pre_rst_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_tx_async", {31'd0, tx}, 32'd1);
        chk("rst_busy_async", {31'd0, busy}, 32'd0);
        chk("rst_ws_async", {16'd0, words_sent}, 32'd0);
        repeat (3) @(negedge clk);
        rd0 = rd_cnt;
        rst = 1'b0;
        wait_done();
        chk("post_rst_rd", rd_cnt - rd0, 32'd1);
        chk("post_rst_ws", {16'd0, words_sent}, 32'd1);

        // Empty FIFO with en high for 1000 cycles
        rd0 = rd_cnt; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("empty_rd", rd_cnt - rd0, 32'd0);
        chk("empty_tx_low_cycles", bad, 32'd0);

        // Wrap of the completed-word counter
        force dut.words_sent_q = 16'hFFFE;
        @(negedge clk);
        release dut.words_sent_q;
        push_word(32'h01020304, 4);
        wait_done();
        chk("ws_ffff", {16'd0, words_sent}, 32'h0000FFFF);
        push_word(32'hF0E1D2C3, 4);
        wait_done();
        chk("ws_wrap", {16'd0, words_sent}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
